mem_lsu: RTL and testbench
==========================

# mem_lsu

Parametrised load/store unit that replaces the single-cycle MEM-stage datapath with a handshaked, multi-cycle memory access engine. It accepts one load or store per transaction from the pipeline and drives a valid/ready data-memory request channel. Boundary-crossing misaligned accesses are either split into two beats or faulted. It returns an aligned, sign- or zero-extended result with fault status to the MEM/WB side.

## Interface
- XLEN, 32: data/register width; 32 or 64. NB = XLEN/8 byte lanes, OFS = log2(NB).
- ADDR_W, 32: address width.
- SPLIT_MISALIGNED, 1: 1 = split boundary-crossing accesses into two beats; 0 = fault any misaligned access.
- MAX_WAIT, 15: cycles allowed in a wait state before timeout; range 1..255.

- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  pipeline request valid.
- req_ready  out  1  LSU idle; request accepted on req_valid && req_ready.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 B, 1 H, 2 W, 3 D.
- req_unsigned  in  1  zero-extend load.
- req_rd  in  5  destination register, returned unchanged.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  ADDR_W  lane-aligned address; low OFS bits are 0.
- mem_we  out  1  write beat.
- mem_be  out  NB  byte enables.
- mem_wdata  out  XLEN  lane-positioned write data.
- mem_rsp_valid  in  1  read data or write ack; one pulse per accepted request.
- mem_rdata  in  XLEN  read data.
- rsp_valid  out  1  one-cycle result pulse.
- rsp_data  out  XLEN  extended load data; 0 for stores and faults.
- rsp_rd  out  5  echoed req_rd.
- rsp_fault  out  1  access faulted.
- rsp_cause  out  2  00 none, 01 misaligned, 10 timeout, 11 illegal size.

## Operation
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP. req_ready = (state==IDLE).
- Accept: register all request fields and compute off = addr[OFS-1:0] and bytes = 1<<size.
- Access checks, evaluated in this priority order:
  - size==3 with XLEN==32: illegal size (cause 11).
  - addr not a multiple of bytes, with SPLIT_MISALIGNED==0: misaligned (cause 01).
  - Either fault: go to RESP with no memory request issued.
- Cross = off+bytes > NB. A misaligned access that stays inside one lane word is a single beat.
- Beat 0:
  - mem_addr = addr with low OFS bits cleared.
  - mem_be = ((1<<bytes)-1) << off, truncated to NB bits.
  - mem_wdata = wdata << 8*off.
- Beat 1 (cross only):
  - mem_addr = beat-0 address + NB.
  - mem_be = remaining low bytes.
  - mem_wdata = wdata >> 8*(NB-off).
- State flow:
  - REQ0: holds mem_req_valid and all mem_* outputs stable until mem_req_ready, then goes to WAIT0.
  - WAIT0: on mem_rsp_valid, captures rdata, then goes to REQ1 if cross, otherwise RESP.
  - REQ1 and WAIT1: same behaviour as REQ0 and WAIT0; WAIT1 goes to RESP.
- Load assembly:
  - Non-cross: raw = rdata0 >> 8*off.
  - Cross: raw = (rdata0 >> 8*off) | (rdata1 << 8*(NB-off)).
  - Mask raw to bytes*8 bits, then sign-extend from the top bit, or zero-extend when req_unsigned.
- Timeout:
  - Wait counter clears on entry to each WAIT state.
  - Reaching MAX_WAIT without mem_rsp_valid: go to RESP with cause 10.
  - A store whose beat 0 completed is not rolled back.
- mem_rsp_valid outside WAIT0/WAIT1 is ignored.
- RESP: rsp_valid=1 for one cycle, then IDLE.

## Timing
- Reset:
  - state=IDLE, req_ready=1.
  - mem_req_valid, mem_we, rsp_valid, rsp_fault = 0.
  - mem_be, mem_addr, mem_wdata, rsp_data, rsp_rd, rsp_cause = 0.
- Reset mid-transaction aborts the transaction and yields the reset values in the next cycle. A subsequent stray mem_rsp_valid is ignored.
- Best-case single-beat latency, with accept at cycle 0:
  - mem_req_valid in cycle 1.
  - mem_rsp_valid in cycle 2 at the earliest.
  - rsp_valid in cycle 3.
- A split access adds 2 cycles minimum.
- Fault path: rsp_valid in cycle 1 and mem_req_valid never asserts.
- Throughput: one transaction in flight. The next accept is possible in the cycle after rsp_valid.
- All outputs are registered.

## Test plan
- SW 0x100, wdata 0xDEADBEEF (XLEN=32) -> one beat: addr 0x100, be 1111, wdata 0xDEADBEEF, we=1; ack -> rsp_valid, rsp_fault=0, rsp_data=0.
- LB 0x103, mem_rdata 0x80FF0000 -> rsp_data 0xFFFFFF80; same access as LBU -> 0x00000080; LH 0x101, mem_rdata 0x00ABCD00 -> single beat, be 0110, rsp_data 0xFFFFABCD.
- LW 0x102, SPLIT=1 -> beat0 addr 0x100, be 1100, rdata 0xAAAA1234; beat1 addr 0x104, be 0011, rdata 0x00005678 -> rsp_data 0x5678AAAA. SH 0x103, wdata 0x1234 -> beat0 be 1000, wdata 0x34000000; beat1 addr 0x104, be 0001, wdata 0x00000012.
- SPLIT=0: LW 0x101 -> no mem_req_valid, rsp_valid in cycle 1, rsp_fault=1, cause 01. XLEN=32 with size=3 -> cause 11.
- MAX_WAIT=4, mem_req_ready=1, no response -> rsp_fault=1, cause 10, rsp_valid 4 cycles after WAIT0 entry, req_ready=1 afterwards; a late mem_rsp_valid is ignored.
- rst pulsed while in WAIT0 -> next cycle reset values with req_ready=1; a new LW 0x200 then completes normally; mem_req_ready held low for 3 cycles -> mem_addr, mem_be and mem_wdata stay stable.

Source files
------------

// File: rtl/mem_lsu.sv
// Handshaked multi-cycle load/store unit: one transaction in flight, optional
// two-beat split of boundary-crossing accesses, timeout and fault reporting.
module mem_lsu #(
    parameter int XLEN             = 32,
    parameter int ADDR_W           = 32,
    parameter int SPLIT_MISALIGNED = 1,
    parameter int MAX_WAIT         = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [4:0]        req_rd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_data,
    output logic [4:0]        rsp_rd,
    output logic              rsp_fault,
    output logic [1:0]        rsp_cause
);

    localparam int NB  = XLEN / 8;
    localparam int OFS = $clog2(NB);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ0  = 3'd1;
    localparam logic [2:0] WAIT0 = 3'd2;
    localparam logic [2:0] REQ1  = 3'd3;
    localparam logic [2:0] WAIT1 = 3'd4;
    localparam logic [2:0] RESP  = 3'd5;

    logic [2:0]        state;
    logic [7:0]        wait_cnt;
    logic              cross_q;
    logic              we_q;
    logic              unsigned_q;
    logic [1:0]        size_q;
    logic [OFS-1:0]    off_q;
    logic [ADDR_W-1:0] addr1_q;
    logic [NB-1:0]     be1_q;
    logic [XLEN-1:0]   wdata1_q;
    logic [XLEN-1:0]   rdata0_q;

    // Request decode, evaluated on the accept cycle straight from req_* inputs.
    int                acc_off;
    int                acc_bytes;
    logic              acc_illegal;
    logic              acc_misal;
    logic              acc_fault;
    logic              acc_cross;
    logic [ADDR_W-1:0] acc_addr0;
    logic [2*NB-1:0]   be_full;
    logic [2*XLEN-1:0] wd_full;

    // NOTE: combinational blocks use blocking '=' with every output given a
    // value on every path, so no latches are inferred.
    always_comb begin
        acc_off     = int'(req_addr[OFS-1:0]);
        acc_bytes   = 1 << req_size;
        acc_illegal = (req_size == 2'd3) && (XLEN == 32);
        acc_misal   = (req_addr[OFS-1:0] & OFS'(acc_bytes - 1)) != '0;
        acc_fault   = acc_illegal || (acc_misal && (SPLIT_MISALIGNED == 0));
        acc_cross   = (acc_off + acc_bytes) > NB;
        acc_addr0   = {req_addr[ADDR_W-1:OFS], {OFS{1'b0}}};
        // Upper halves of these double-width vectors are the second beat.
        be_full     = (2*NB)'((1 << acc_bytes) - 1) << acc_off;
        wd_full     = {{XLEN{1'b0}}, req_wdata} << (8 * acc_off);
    end

    // Load assembly: in WAIT0 the low word is arriving now, in WAIT1 it was captured.
    logic [XLEN-1:0]        lo_word;
    logic [XLEN-1:0]        raw;
    logic [XLEN-1:0]        tmp;
    logic signed [XLEN-1:0] tmp_s;
    logic signed [XLEN-1:0] sext;
    logic [XLEN-1:0]        load_ext;
    int                     sh;

    always_comb begin
        lo_word = (state == WAIT0) ? mem_rdata : rdata0_q;
        raw     = lo_word >> (8 * int'(off_q));
        if (cross_q && state == WAIT1)
            raw = raw | (mem_rdata << (8 * (NB - int'(off_q))));
        sh = XLEN - 8 * (1 << size_q);
        if (sh < 0)
            sh = 0;
        tmp   = raw << sh;
        tmp_s = tmp;
        sext  = tmp_s >>> sh;
        if (unsigned_q)
            load_ext = tmp >> sh;
        else
            load_ext = sext;
    end

    logic timeout;
    assign timeout = (wait_cnt == 8'(MAX_WAIT - 1));

    // NOTE: every register, datapath included, is cleared by reset because the
    // outputs are registered and must read zero right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            wait_cnt      <= '0;
            cross_q       <= 1'b0;
            we_q          <= 1'b0;
            unsigned_q    <= 1'b0;
            size_q        <= '0;
            off_q         <= '0;
            addr1_q       <= '0;
            be1_q         <= '0;
            wdata1_q      <= '0;
            rdata0_q      <= '0;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_we        <= 1'b0;
            mem_be        <= '0;
            mem_wdata     <= '0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_rd        <= '0;
            rsp_fault     <= 1'b0;
            rsp_cause     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready  <= 1'b0;
                        rsp_rd     <= req_rd;
                        we_q       <= req_we;
                        unsigned_q <= req_unsigned;
                        size_q     <= req_size;
                        off_q      <= req_addr[OFS-1:0];
                        cross_q    <= acc_cross;
                        addr1_q    <= acc_addr0 + ADDR_W'(NB);
                        be1_q      <= be_full[2*NB-1:NB];
                        wdata1_q   <= wd_full[2*XLEN-1:XLEN];
                        if (acc_fault) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_fault <= 1'b1;
                            rsp_cause <= acc_illegal ? 2'b11 : 2'b01;
                            rsp_data  <= '0;
                        end else begin
                            state         <= REQ0;
                            mem_req_valid <= 1'b1;
                            mem_addr      <= acc_addr0;
                            mem_be        <= be_full[NB-1:0];
                            mem_wdata     <= wd_full[XLEN-1:0];
                            mem_we        <= req_we;
                        end
                    end
                end
                REQ0, REQ1: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        wait_cnt      <= '0;
                        state         <= (state == REQ0) ? WAIT0 : WAIT1;
                    end
                end
                WAIT0, WAIT1: begin
                    if (mem_rsp_valid) begin
                        if (state == WAIT0 && cross_q) begin
                            rdata0_q      <= mem_rdata;
                            state         <= REQ1;
                            mem_req_valid <= 1'b1;
                            mem_addr      <= addr1_q;
                            mem_be        <= be1_q;
                            mem_wdata     <= wdata1_q;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_fault <= 1'b0;
                            rsp_cause <= 2'b00;
                            rsp_data  <= we_q ? '0 : load_ext;
                        end
                    end else if (timeout) begin
                        // A store beat already written stays written.
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_fault <= 1'b1;
                        rsp_cause <= 2'b10;
                        rsp_data  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: table of single/split transactions with a
// scoreboard queue, plus hand sequences for faults, timeout and reset abort.
module tb_mem_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_valid_b;
    logic [31:0] req_addr, req_wdata;
    logic        req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [4:0]  req_rd;
    logic        mem_req_ready, mem_rsp_valid;
    logic [31:0] mem_rdata;

    logic        req_ready, mem_req_valid, mem_we, rsp_valid, rsp_fault;
    logic [31:0] mem_addr, mem_wdata, rsp_data;
    logic [3:0]  mem_be;
    logic [4:0]  rsp_rd;
    logic [1:0]  rsp_cause;

    logic        req_ready_b, mem_req_valid_b, mem_we_b, rsp_valid_b, rsp_fault_b;
    logic [31:0] mem_addr_b, mem_wdata_b, rsp_data_b;
    logic [3:0]  mem_be_b;
    logic [4:0]  rsp_rd_b;
    logic [1:0]  rsp_cause_b;
    logic        mem_req_ready_b = 1'b1;
    logic        mem_rsp_valid_b = 1'b0;

    mem_lsu #(.XLEN(32), .ADDR_W(32), .SPLIT_MISALIGNED(1), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_rd(req_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
        .rsp_fault(rsp_fault), .rsp_cause(rsp_cause)
    );

    mem_lsu #(.XLEN(32), .ADDR_W(32), .SPLIT_MISALIGNED(0), .MAX_WAIT(4)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_rd(req_rd),
        .mem_req_valid(mem_req_valid_b), .mem_req_ready(mem_req_ready_b),
        .mem_addr(mem_addr_b), .mem_we(mem_we_b), .mem_be(mem_be_b), .mem_wdata(mem_wdata_b),
        .mem_rsp_valid(mem_rsp_valid_b), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .rsp_rd(rsp_rd_b),
        .rsp_fault(rsp_fault_b), .rsp_cause(rsp_cause_b)
    );

    int checks = 0;
    int errors = 0;
    logic seen_b_req = 1'b0;

    always @(posedge clk) if (mem_req_valid_b) seen_b_req <= 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [4:0]  rd;
        int          nbeats;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic [31:0] rd0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic [31:0] rd1;
        logic [31:0] exp_data;
    } vec_t;

    function automatic vec_t mk(
        logic we, logic [31:0] addr, logic [1:0] size, logic uns, logic [31:0] wdata,
        logic [4:0] rd, int nb,
        logic [31:0] a0, logic [3:0] be0, logic [31:0] wd0, logic [31:0] rd0,
        logic [31:0] a1, logic [3:0] be1, logic [31:0] wd1, logic [31:0] rd1,
        logic [31:0] exp_data);
        vec_t v;
        v.we = we; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wdata;
        v.rd = rd; v.nbeats = nb;
        v.a0 = a0; v.be0 = be0; v.wd0 = wd0; v.rd0 = rd0;
        v.a1 = a1; v.be1 = be1; v.wd1 = wd1; v.rd1 = rd1;
        v.exp_data = exp_data;
        return v;
    endfunction

    vec_t vec[13];
    vec_t exp_q[$];

    task automatic drive_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                             input logic uns, input logic [31:0] wdata, input logic [4:0] rd);
        req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata; req_rd = rd;
    endtask

    task automatic do_txn(input int i);
        vec_t v;
        vec_t e;
        int   n;
        v = vec[i];
        check($sformatf("v%0d req_ready", i), req_ready, 1);
        drive_req(v.we, v.addr, v.size, v.uns, v.wdata, v.rd);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        exp_q.push_back(v);
        for (int b = 0; b < v.nbeats; b++) begin
            n = 0;
            while (!mem_req_valid && n < 16) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("v%0d b%0d req_lat", i, b), n, 0);
            check($sformatf("v%0d b%0d addr", i, b), mem_addr, (b == 0) ? v.a0 : v.a1);
            check($sformatf("v%0d b%0d be", i, b), mem_be, (b == 0) ? v.be0 : v.be1);
            check($sformatf("v%0d b%0d wdata", i, b), mem_wdata, (b == 0) ? v.wd0 : v.wd1);
            check($sformatf("v%0d b%0d we", i, b), mem_we, v.we);
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            check($sformatf("v%0d b%0d req_drop", i, b), mem_req_valid, 0);
            mem_rsp_valid = 1'b1;
            mem_rdata = (b == 0) ? v.rd0 : v.rd1;
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            mem_rdata = '0;
        end
        n = 0;
        while (!rsp_valid && n < 16) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("v%0d rsp_lat", i), n, 0);
        e = exp_q.pop_front();
        check($sformatf("v%0d rsp_data", i), rsp_data, e.exp_data);
        check($sformatf("v%0d rsp_fault", i), rsp_fault, 0);
        check($sformatf("v%0d rsp_cause", i), rsp_cause, 0);
        check($sformatf("v%0d rsp_rd", i), rsp_rd, e.rd);
        @(negedge clk);
        check($sformatf("v%0d rsp_pulse", i), rsp_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        vec[0]  = mk(1, 32'h100, 2, 0, 32'hDEADBEEF, 5'd1, 1,
                     32'h100, 4'b1111, 32'hDEADBEEF, 32'h0, 0, 0, 0, 0, 32'h0);
        vec[1]  = mk(0, 32'h103, 0, 0, 32'h0, 5'd2, 1,
                     32'h100, 4'b1000, 32'h0, 32'h80FF0000, 0, 0, 0, 0, 32'hFFFFFF80);
        vec[2]  = mk(0, 32'h103, 0, 1, 32'h0, 5'd3, 1,
                     32'h100, 4'b1000, 32'h0, 32'h80FF0000, 0, 0, 0, 0, 32'h00000080);
        vec[3]  = mk(0, 32'h101, 1, 0, 32'h0, 5'd4, 1,
                     32'h100, 4'b0110, 32'h0, 32'h00ABCD00, 0, 0, 0, 0, 32'hFFFFABCD);
        vec[4]  = mk(0, 32'h102, 2, 0, 32'h0, 5'd5, 2,
                     32'h100, 4'b1100, 32'h0, 32'hAAAA1234,
                     32'h104, 4'b0011, 32'h0, 32'h00005678, 32'h5678AAAA);
        vec[5]  = mk(1, 32'h103, 1, 0, 32'h00001234, 5'd6, 2,
                     32'h100, 4'b1000, 32'h34000000, 32'h0,
                     32'h104, 4'b0001, 32'h00000012, 32'h0, 32'h0);
        vec[6]  = mk(0, 32'h106, 1, 1, 32'h0, 5'd7, 1,
                     32'h104, 4'b1100, 32'h0, 32'h80010000, 0, 0, 0, 0, 32'h00008001);
        vec[7]  = mk(0, 32'h10A, 1, 0, 32'h0, 5'd8, 1,
                     32'h108, 4'b1100, 32'h0, 32'h80010000, 0, 0, 0, 0, 32'hFFFF8001);
        vec[8]  = mk(0, 32'h200, 2, 0, 32'h0, 5'd9, 1,
                     32'h200, 4'b1111, 32'h0, 32'h12345678, 0, 0, 0, 0, 32'h12345678);
        vec[9]  = mk(1, 32'h201, 0, 0, 32'h000000A5, 5'd10, 1,
                     32'h200, 4'b0010, 32'h0000A500, 32'h0, 0, 0, 0, 0, 32'h0);
        vec[10] = mk(0, 32'h103, 1, 0, 32'h0, 5'd11, 2,
                     32'h100, 4'b1000, 32'h0, 32'h7F000000,
                     32'h104, 4'b0001, 32'h0, 32'h000000FF, 32'hFFFFFF7F);
        vec[11] = mk(1, 32'h107, 2, 0, 32'h11223344, 5'd12, 2,
                     32'h104, 4'b1000, 32'h44000000, 32'h0,
                     32'h108, 4'b0111, 32'h00112233, 32'h0, 32'h0);
        vec[12] = mk(0, 32'h100, 0, 0, 32'h0, 5'd31, 1,
                     32'h100, 4'b0001, 32'h0, 32'h0000007F, 0, 0, 0, 0, 32'h0000007F);

        rst = 1'b1;
        req_valid = 1'b0; req_valid_b = 1'b0;
        drive_req(0, 0, 0, 0, 0, 0);
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst req_ready", req_ready, 1);
        check("rst mem_req_valid", mem_req_valid, 0);
        check("rst mem_we", mem_we, 0);
        check("rst rsp_valid", rsp_valid, 0);
        check("rst rsp_fault", rsp_fault, 0);
        check("rst mem_be", mem_be, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_wdata", mem_wdata, 0);
        check("rst rsp_data", rsp_data, 0);
        check("rst rsp_rd", rsp_rd, 0);
        check("rst rsp_cause", rsp_cause, 0);

        for (int i = 0; i < 13; i++) do_txn(i);

        // Non-split instance: misaligned word faults at once
        drive_req(0, 32'h101, 2, 0, 0, 5'd17);
        req_valid_b = 1'b1;
        @(negedge clk);
        req_valid_b = 1'b0;
        check("mis rsp_valid", rsp_valid_b, 1);
        check("mis rsp_fault", rsp_fault_b, 1);
        check("mis rsp_cause", rsp_cause_b, 2'b01);
        check("mis rsp_data", rsp_data_b, 0);
        check("mis rsp_rd", rsp_rd_b, 17);
        check("mis mem_req_valid", mem_req_valid_b, 0);
        @(negedge clk);
        check("mis rsp_pulse", rsp_valid_b, 0);
        check("mis req_ready", req_ready_b, 1);

        // Illegal size outranks misalignment
        drive_req(0, 32'h101, 3, 0, 0, 5'd18);
        req_valid_b = 1'b1;
        @(negedge clk);
        req_valid_b = 1'b0;
        check("ill_b rsp_valid", rsp_valid_b, 1);
        check("ill_b rsp_cause", rsp_cause_b, 2'b11);
        @(negedge clk);

        // Illegal size on split instance
        drive_req(0, 32'h100, 3, 0, 0, 5'd19);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("ill_a rsp_valid", rsp_valid, 1);
        check("ill_a rsp_fault", rsp_fault, 1);
        check("ill_a rsp_cause", rsp_cause, 2'b11);
        check("ill_a mem_req_valid", mem_req_valid, 0);
        @(negedge clk);
        check("b never requested", seen_b_req, 0);

        // Timeout: MAX_WAIT=4, memory accepts but never answers
        mem_req_ready = 1'b1;
        drive_req(0, 32'h300, 2, 0, 0, 5'd20);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        mem_req_ready = 1'b0;
        check("to rsp_cycle", cyc, 6);
        check("to rsp_fault", rsp_fault, 1);
        check("to rsp_cause", rsp_cause, 2'b10);
        check("to rsp_data", rsp_data, 0);
        check("to rsp_rd", rsp_rd, 20);
        @(negedge clk);
        check("to req_ready", req_ready, 1);
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rdata = '0;
        check("late rsp_valid", rsp_valid, 0);
        check("late mem_req_valid", mem_req_valid, 0);
        check("late req_ready", req_ready, 1);

        // Reset while in WAIT0
        mem_req_ready = 1'b1;
        drive_req(0, 32'h300, 2, 0, 0, 5'd22);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort req_ready", req_ready, 1);
        check("abort mem_req_valid", mem_req_valid, 0);
        check("abort rsp_valid", rsp_valid, 0);
        check("abort mem_addr", mem_addr, 0);
        check("abort mem_be", mem_be, 0);
        check("abort rsp_rd", rsp_rd, 0);
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'h55555555;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check("stray rsp_valid", rsp_valid, 0);
        check("stray req_ready", req_ready, 1);

        // LW 0x200 with mem_req_ready low for three cycles
        drive_req(0, 32'h200, 2, 0, 0, 5'd21);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("stall%0d valid", k), mem_req_valid, 1);
            check($sformatf("stall%0d addr", k), mem_addr, 32'h200);
            check($sformatf("stall%0d be", k), mem_be, 4'b1111);
            check($sformatf("stall%0d wdata", k), mem_wdata, 0);
            @(negedge clk);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rdata = '0;
        check("post rsp_valid", rsp_valid, 1);
        check("post rsp_data", rsp_data, 32'hCAFEF00D);
        check("post rsp_fault", rsp_fault, 0);
        check("post rsp_rd", rsp_rd, 21);
        @(negedge clk);
        check("post req_ready", req_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
